// File: rtl/cdb_write_arbiter_pkg.sv
// Shared constants for the common-data-bus write arbiter: default widths,
// requester count, and the component-ID encoding used in the tag high nibble.
package cdb_write_arbiter_pkg;

  localparam int WordWidth               = 32;
  localparam int Def_RegisterSelectWidth = 4;
  localparam int ByteWidth               = 8;
  localparam int NUM_REQ_DEF             = 4;

  // Producing-component identifiers, placed in tag[7:4].
  typedef enum logic [3:0] {
    COMP_ALU = 4'd0,
    COMP_MUL = 4'd1,
    COMP_LSU = 4'd2,
    COMP_BRU = 4'd3
  } comp_id_e;

  // Tag = {component ID, entry number within that component}.
  function automatic logic [7:0] make_tag(comp_id_e comp, logic [3:0] entry);
    return {comp, entry};
  endfunction

endpackage

// File: rtl/cdb_write_arbiter_if.sv
// Write-request handshake and bus bundle between function units (master)
// and the common-data-bus arbiter (slave).
interface cdb_write_arbiter_if
  import cdb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = WordWidth,
  parameter int REG_W   = Def_RegisterSelectWidth,
  parameter int TAG_W   = ByteWidth
);
  logic [NUM_REQ-1:0]        in_WriteRequest;
  logic [NUM_REQ*DATA_W-1:0] in_WriteData;
  logic [NUM_REQ*REG_W-1:0]  in_WriteRegisterNumber;
  logic [NUM_REQ*TAG_W-1:0]  in_WriteComponentEntry;

  logic [NUM_REQ-1:0]        out_WriteGrant;
  logic [DATA_W-1:0]         out_WriteBus;
  logic [REG_W-1:0]          out_WriteRegisterNumber;
  logic [TAG_W-1:0]          out_WriteComponentEntry;
  logic                      out_WriteRegisterEnable;

  // Function-unit side.
  modport master (
    output in_WriteRequest, in_WriteData, in_WriteRegisterNumber, in_WriteComponentEntry,
    input  out_WriteGrant, out_WriteBus, out_WriteRegisterNumber,
           out_WriteComponentEntry, out_WriteRegisterEnable
  );

  // Arbiter side.
  modport slave (
    input  in_WriteRequest, in_WriteData, in_WriteRegisterNumber, in_WriteComponentEntry,
    output out_WriteGrant, out_WriteBus, out_WriteRegisterNumber,
           out_WriteComponentEntry, out_WriteRegisterEnable
  );
endinterface

// File: rtl/cdb_write_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first requester at or after
// the pointer, wrapping to index 0. Returns one-hot winner, its index, valid.
module cdb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);
  // Requests at or above the pointer get first priority.
  logic [NUM_REQ-1:0] upper;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_upper
      assign upper[gi] = req_i[gi] & (ptr_i <= PTR_W'(gi));
    end
  endgenerate

  // Lowest set bit of the upper group, else lowest set bit overall (wrap).
  always_comb begin
    logic found;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && upper[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = i[PTR_W-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = i[PTR_W-1:0];
      end
    end
  end
endmodule

// File: rtl/cdb_write_arbiter.sv
// Common-data-bus write arbiter: round-robin grant among NUM_REQ function
// units, captures the granted unit's result during its grant cycle and drives
// it on the bus one cycle later with a single-cycle write enable.
// Optional build macro CDB_OCCUPANCY_CNT_EN adds a saturating 16-bit count of
// bus-busy cycles on out_BusBusyCount.
module cdb_write_arbiter
  import cdb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = WordWidth,
  parameter int REG_W   = Def_RegisterSelectWidth,
  parameter int TAG_W   = ByteWidth
) (
  input logic clock,
  input logic reset,
  cdb_write_arbiter_if.slave cdb
`ifdef CDB_OCCUPANCY_CNT_EN
  ,
  output logic [15:0] out_BusBusyCount
`endif
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] eligible, pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;

  logic               en_q, en_d;
  logic [DATA_W-1:0]  bus_q, bus_d;
  logic [REG_W-1:0]   reg_q, reg_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  // The unit currently holding the grant still has its request up; mask it so
  // it is not granted twice for one transfer.
  assign eligible = cdb.in_WriteRequest & ~grant_q;

  cdb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Per-unit slices gated by the grant, so the capture mux is a plain OR.
  logic [DATA_W-1:0] data_sel [NUM_REQ];
  logic [REG_W-1:0]  reg_sel  [NUM_REQ];
  logic [TAG_W-1:0]  tag_sel  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign data_sel[gi] = cdb.in_WriteData[gi*DATA_W +: DATA_W] & {DATA_W{grant_q[gi]}};
      assign reg_sel[gi]  = cdb.in_WriteRegisterNumber[gi*REG_W +: REG_W] & {REG_W{grant_q[gi]}};
      assign tag_sel[gi]  = cdb.in_WriteComponentEntry[gi*TAG_W +: TAG_W] & {TAG_W{grant_q[gi]}};
    end
  endgenerate

  // Next grant and pointer; pointer advances past the winner, holds when idle.
  always_comb begin
    grant_d = pick_valid ? pick_grant : '0;
    ptr_d   = ptr_q;
    if (pick_valid) begin
      ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Capture the granted slice; the bus keeps its last value when idle.
  always_comb begin
    en_d  = |grant_q;
    bus_d = bus_q;
    reg_d = reg_q;
    tag_d = tag_q;
    if (|grant_q) begin
      bus_d = '0;
      reg_d = '0;
      tag_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        bus_d = bus_d | data_sel[i];
        reg_d = reg_d | reg_sel[i];
        tag_d = tag_d | tag_sel[i];
      end
    end
  end

  // Arbitration and bus registers; reset discards any in-flight transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      ptr_q   <= '0;
      en_q    <= 1'b0;
      bus_q   <= '0;
      reg_q   <= '0;
      tag_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      bus_q   <= bus_d;
      reg_q   <= reg_d;
      tag_q   <= tag_d;
    end
  end

  assign cdb.out_WriteGrant          = grant_q;
  assign cdb.out_WriteBus            = bus_q;
  assign cdb.out_WriteRegisterNumber = reg_q;
  assign cdb.out_WriteComponentEntry = tag_q;
  assign cdb.out_WriteRegisterEnable = en_q;

`ifdef CDB_OCCUPANCY_CNT_EN
  logic [15:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (en_q && (busy_cnt_q != 16'hFFFF)) begin
      busy_cnt_d = busy_cnt_q + 16'd1;
    end
  end

  // Saturating count of cycles the bus carried a write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign out_BusBusyCount = busy_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_write_arbiter.sv
// Bench for cdb_write_arbiter: directed scenarios followed by random request
// traffic, checked every cycle against a transaction-level reference model.
module tb_cdb_write_arbiter;
  import cdb_write_arbiter_pkg::*;

  localparam int N = 4;

  logic clock;
  logic reset;

  cdb_write_arbiter_if #(.NUM_REQ(N), .DATA_W(32), .REG_W(4), .TAG_W(8)) cdb ();

`ifdef CDB_OCCUPANCY_CNT_EN
  logic [15:0] busy_cnt;
`endif

  cdb_write_arbiter #(.NUM_REQ(N), .DATA_W(32), .REG_W(4), .TAG_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .cdb   (cdb.slave)
`ifdef CDB_OCCUPANCY_CNT_EN
    ,
    .out_BusBusyCount (busy_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: what the DUT outputs should show right now.
  logic [N-1:0] m_grant, m_gprev;
  int           m_ptr;
  logic         m_en;
  logic [31:0]  m_bus;
  logic [3:0]   m_reg;
  logic [7:0]   m_tag;
  int           m_cnt;

  logic [N-1:0] obs_gprev;
  logic [N-1:0] hold;
  bit           rnd_en;
  int           gcount;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = '0; m_gprev = '0; m_ptr = 0; m_en = 1'b0;
    m_bus = '0; m_reg = '0; m_tag = '0; m_cnt = 0;
  endtask

  // One clock of the arbiter rules: transfer from last grant, then arbitrate.
  task automatic model_update();
    logic [N-1:0] elig;
    int w;
    if (m_en && m_cnt < 65535) m_cnt++;
    m_gprev = m_grant;
    m_en    = (m_grant != 0);
    for (int i = 0; i < N; i++) begin
      if (m_grant[i]) begin
        m_bus = cdb.in_WriteData[i*32 +: 32];
        m_reg = cdb.in_WriteRegisterNumber[i*4 +: 4];
        m_tag = cdb.in_WriteComponentEntry[i*8 +: 8];
      end
    end
    elig = cdb.in_WriteRequest & ~m_grant;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int u;
      u = (m_ptr + k) % N;
      if (w < 0 && elig[u]) w = u;
    end
    m_grant = '0;
    if (w >= 0) begin
      m_grant[w] = 1'b1;
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic check_all();
    chk("grant", 64'(cdb.out_WriteGrant), 64'(m_grant));
    chk("enable", 64'(cdb.out_WriteRegisterEnable), 64'(m_en));
    chk("bus", 64'(cdb.out_WriteBus), 64'(m_bus));
    chk("regnum", 64'(cdb.out_WriteRegisterNumber), 64'(m_reg));
    chk("tag", 64'(cdb.out_WriteComponentEntry), 64'(m_tag));
    chk("pointer", 64'(dut.ptr_q), 64'(m_ptr));
    chk("grant_onehot0", 64'($onehot0(cdb.out_WriteGrant)), 64'd1);
    chk("enable_vs_grant_d1", 64'(cdb.out_WriteRegisterEnable), 64'(obs_gprev != 0));
`ifdef CDB_OCCUPANCY_CNT_EN
    chk("busy_count", 64'(busy_cnt), 64'(m_cnt));
`endif
    obs_gprev = cdb.out_WriteGrant;
  endtask

  task automatic set_unit(input int i, input logic [31:0] d, input logic [3:0] r, input logic [7:0] t);
    cdb.in_WriteData[i*32 +: 32]         = d;
    cdb.in_WriteRegisterNumber[i*4 +: 4] = r;
    cdb.in_WriteComponentEntry[i*8 +: 8] = t;
  endtask

  // Requesters: drop in the cycle after the grant; optionally raise new ones.
  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (m_gprev[i] && !hold[i]) cdb.in_WriteRequest[i] = 1'b0;
      if (rnd_en && !cdb.in_WriteRequest[i] && !m_grant[i] && $urandom_range(2) == 0) begin
        cdb.in_WriteRequest[i] = 1'b1;
        set_unit(i, $urandom, 4'($urandom_range(15)),
                 make_tag(comp_id_e'(4'(i)), 4'($urandom_range(15))));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    if (reset) model_reset();
    else model_update();
    @(negedge clock);
    check_all();
    drive_reqs();
    $display("t=%0t req=%b grant=%b en=%b bus=%h reg=%h tag=%h", $time,
             cdb.in_WriteRequest, cdb.out_WriteGrant, cdb.out_WriteRegisterEnable,
             cdb.out_WriteBus, cdb.out_WriteRegisterNumber, cdb.out_WriteComponentEntry);
  endtask

  initial begin
    reset = 1'b1;
    cdb.in_WriteRequest        = '0;
    cdb.in_WriteData           = '0;
    cdb.in_WriteRegisterNumber = '0;
    cdb.in_WriteComponentEntry = '0;
    hold = '0; rnd_en = 1'b0; obs_gprev = '0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_grant", 64'(cdb.out_WriteGrant), 64'd0);
    chk("rst_enable", 64'(cdb.out_WriteRegisterEnable), 64'd0);
    chk("rst_bus", 64'(cdb.out_WriteBus), 64'd0);
    reset = 1'b0;

    // Idle for 10 cycles.
    repeat (10) cycle();
    chk("idle_ptr", 64'(dut.ptr_q), 64'd0);

    // Single uncontended request from unit 2.
    cdb.in_WriteRequest[2] = 1'b1;
    set_unit(2, 32'h0000_1234, 4'd5, 8'h02);
    cycle();
    chk("u2_grant", 64'(cdb.out_WriteGrant), 64'b0100);
    cycle();
    chk("u2_enable", 64'(cdb.out_WriteRegisterEnable), 64'd1);
    chk("u2_bus", 64'(cdb.out_WriteBus), 64'h1234);
    chk("u2_reg", 64'(cdb.out_WriteRegisterNumber), 64'd5);
    chk("u2_tag", 64'(cdb.out_WriteComponentEntry), 64'h02);
    repeat (3) cycle();

    // Reset pointer, then units 0,1,3 contend.
    @(negedge clock); reset = 1'b1; #1; model_reset(); obs_gprev = '0;
    @(negedge clock); reset = 1'b0;
    set_unit(0, 32'hA000_0000, 4'd1, 8'h00);
    set_unit(1, 32'hB111_1111, 4'd2, 8'h11);
    set_unit(3, 32'hD333_3333, 4'd3, 8'h33);
    cdb.in_WriteRequest = 4'b1011;
    cycle();
    chk("rr_g0", 64'(cdb.out_WriteGrant), 64'b0001);
    cycle();
    chk("rr_g1", 64'(cdb.out_WriteGrant), 64'b0010);
    chk("rr_bus0", 64'(cdb.out_WriteBus), 64'hA000_0000);
    cycle();
    chk("rr_g3", 64'(cdb.out_WriteGrant), 64'b1000);
    chk("rr_bus1", 64'(cdb.out_WriteBus), 64'hB111_1111);
    cycle();
    chk("rr_bus3", 64'(cdb.out_WriteBus), 64'hD333_3333);
    chk("rr_ptr", 64'(dut.ptr_q), 64'd0);
    repeat (2) cycle();

    // Unit 1 holds its request: granted every other cycle.
    hold[1] = 1'b1;
    cdb.in_WriteRequest[1] = 1'b1;
    set_unit(1, 32'hCAFE_0001, 4'd9, 8'h21);
    gcount = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (cdb.out_WriteGrant[1]) gcount++;
    end
    chk("hold_grants", 64'(gcount), 64'd4);
    hold[1] = 1'b0;
    repeat (4) cycle();

    // Reset in the cycle after a grant discards the transfer.
    cdb.in_WriteRequest[0] = 1'b1;
    set_unit(0, 32'h5555_AAAA, 4'd7, 8'h07);
    cycle();
    chk("rst_mid_grant", 64'(cdb.out_WriteGrant), 64'b0001);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_grant", 64'(cdb.out_WriteGrant), 64'd0);
    chk("rst_async_enable", 64'(cdb.out_WriteRegisterEnable), 64'd0);
    chk("rst_async_bus", 64'(cdb.out_WriteBus), 64'd0);
    chk("rst_async_reg", 64'(cdb.out_WriteRegisterNumber), 64'd0);
    chk("rst_async_tag", 64'(cdb.out_WriteComponentEntry), 64'd0);
    model_reset(); obs_gprev = '0;
    cdb.in_WriteRequest = '0;
    @(negedge clock); reset = 1'b0;
    repeat (3) cycle();

    // Random traffic.
    rnd_en = 1'b1;
    repeat (300) cycle();
    rnd_en = 1'b0;
    repeat (10) cycle();

`ifdef CDB_OCCUPANCY_CNT_EN
    @(negedge clock); reset = 1'b1; #1; model_reset(); obs_gprev = '0;
    cdb.in_WriteRequest = '0;
    @(negedge clock); reset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      cdb.in_WriteRequest[t % N] = 1'b1;
      set_unit(t % N, 32'(t + 100), 4'(t), 8'(t));
      repeat (3) cycle();
    end
    chk("cnt_five", 64'(busy_cnt), 64'd5);
    force dut.busy_cnt_q = 16'hFFFE;
    #1 release dut.busy_cnt_q;
    m_cnt = 65534;
    for (int t = 0; t < 3; t++) begin
      cdb.in_WriteRequest[t] = 1'b1;
      set_unit(t, 32'(t + 200), 4'(t), 8'(t));
      repeat (3) cycle();
    end
    chk("cnt_saturate", 64'(busy_cnt), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
